code_verifier: RTL

- Parametrised code-entry verifier for the lock datapath; the generalised successor of the fixed 4-digit, always-match sequence checker.
- Accepts one digit per valid strobe and compares it against the stored code slice for that position.
- After DIGITS entries it issues a one-cycle unlock or fail pulse, counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures.
- Sits between the keypad/debounce front end and the door actuator/display logic.

---
 rtl/code_verifier_if.sv | 30 +++
 rtl/code_verifier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/code_verifier_if.sv
// Keypad-side bundle for the code verifier: entry strobes in, verdict and status out.
// The master drives digits/code/clear; the slave (the verifier) returns registered status.
interface code_verifier_if #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(MAX_TRIES + 1);

  logic                      digit_valid;
  logic [DIGIT_W-1:0]        digit;
  logic [DIGITS*DIGIT_W-1:0] code;
  logic                      clear;
  logic                      unlock;
  logic                      fail;
  logic                      locked_out;
  logic [AW-1:0]             attempts_left;
  logic [CW-1:0]             digit_count;

  modport master (
    output digit_valid, digit, code, clear,
    input  unlock, fail, locked_out, attempts_left, digit_count
  );

  modport slave (
    input  digit_valid, digit, code, clear,
    output unlock, fail, locked_out, attempts_left, digit_count
  );
endinterface

// File: rtl/code_verifier.sv
// Code-entry verifier: collects DIGITS digits, pulses unlock/fail one cycle after the last
// digit, and enters a timed lockout after MAX_TRIES consecutive wrong entries.
module code_verifier #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  code_verifier_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX  = CW'(DIGITS - 1);
  localparam logic [AW-1:0] MAX_A     = AW'(MAX_TRIES);
  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] ONE_L     = LW'(1);

  typedef enum logic {COLLECT, LOCKOUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic          unlock_q, unlock_d;
  logic          fail_q, fail_d;
  logic          locked_q, locked_d;
  logic [AW-1:0] att_q, att_d;
  logic [LW-1:0] lock_q, lock_d;

  logic [DIGIT_W-1:0] slice;
  logic               mis_now;
  logic               last_digit;
  logic               accept;

  // Slice selection, running mismatch including the current digit, and "this digit completes".
  assign slice      = bus.code[int'(cnt_q)*DIGIT_W +: DIGIT_W];
  assign mis_now    = mis_q | (bus.digit != slice);
  assign last_digit = (cnt_q == LAST_IDX);
  assign accept     = (state_q == COLLECT) && bus.digit_valid && !bus.clear;

  // State register (all flops, including registered outputs).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
      att_q    <= MAX_A;
      lock_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
      unlock_q <= unlock_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
      att_q    <= att_d;
      lock_q   <= lock_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (accept && last_digit && mis_now && (att_q == ONE_A)) state_d = LOCKOUT;
      LOCKOUT: if (lock_q == ONE_L) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    unlock_d = 1'b0;
    fail_d   = 1'b0;
    locked_d = locked_q;
    att_d    = att_q;
    lock_d   = lock_q;
    unique case (state_q)
      COLLECT: begin
        if (bus.clear) begin
          cnt_d = '0;
          mis_d = 1'b0;
        end else if (bus.digit_valid) begin
          if (last_digit) begin
            // Verdict covers the whole entry; the next entry may start on the very next cycle.
            cnt_d = '0;
            mis_d = 1'b0;
            if (mis_now) begin
              fail_d = 1'b1;
              att_d  = att_q - ONE_A;
              if (att_q == ONE_A) begin
                locked_d = 1'b1;
                lock_d   = LOCK_INIT;
              end
            end else begin
              unlock_d = 1'b1;
              att_d    = MAX_A;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            mis_d = mis_now;
          end
        end
      end
      LOCKOUT: begin
        cnt_d  = '0;
        lock_d = lock_q - ONE_L;
        if (lock_q == ONE_L) begin
          locked_d = 1'b0;
          att_d    = MAX_A;
        end
      end
      default: begin
        cnt_d = '0;
        mis_d = 1'b0;
      end
    endcase
  end

  assign bus.unlock        = unlock_q;
  assign bus.fail          = fail_q;
  assign bus.locked_out    = locked_q;
  assign bus.attempts_left = att_q;
  assign bus.digit_count   = cnt_q;
endmodule
